// File: rtl/vga_timing_gen.sv
// VGA/VESA timing generator: free-running h/v counters, sync/active decodes,
// scaled framebuffer address and a delay line matching framebuffer read latency.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 1024,
  parameter int H_FPORCH    = 24,
  parameter int H_PULSE     = 136,
  parameter int H_BPORCH    = 160,
  parameter int V_ACTIVE    = 768,
  parameter int V_FPORCH    = 3,
  parameter int V_PULSE     = 6,
  parameter int V_BPORCH    = 29,
  parameter bit H_POL       = 1'b0,
  parameter bit V_POL       = 1'b0,
  parameter int SCALE_SHIFT = 2,
  parameter int FB_AW       = 16,
  parameter int PIPE        = 1,
  parameter int CW          = 13
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  output logic [CW-1:0]    h,
  output logic [CW-1:0]    v,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             line_start,
  output logic             frame_start,
  output logic [FB_AW-1:0] fb_addr,
  output logic             hsync_d,
  output logic             vsync_d,
  output logic             active_d
);

  localparam int H_TOTAL = H_ACTIVE + H_FPORCH + H_PULSE + H_BPORCH;
  localparam int V_TOTAL = V_ACTIVE + V_FPORCH + V_PULSE + V_BPORCH;

  localparam logic [CW-1:0] H_MAX  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FPORCH);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FPORCH + H_PULSE);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FPORCH);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FPORCH + V_PULSE);

  localparam logic [CW-1:0]    SUB_MASK = CW'((1 << SCALE_SHIFT) - 1);
  localparam logic [FB_AW-1:0] ROW_W    = FB_AW'(H_ACTIVE >> SCALE_SHIFT);

  localparam longint FB_WORDS = longint'(H_ACTIVE >> SCALE_SHIFT) * longint'(V_ACTIVE >> SCALE_SHIFT);

  generate
    if (FB_WORDS > (longint'(1) << FB_AW)) begin : g_err_fb
      $fatal(1, "vga_timing_gen: scaled framebuffer does not fit in FB_AW address bits");
    end
    if (H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW)) begin : g_err_cw
      $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
    end
    if (PIPE < 0 || PIPE > 4) begin : g_err_pipe
      $fatal(1, "vga_timing_gen: PIPE must be within 0..4");
    end
  endgenerate

  logic             h_wrap;
  logic [CW-1:0]    v_next;
  logic [FB_AW-1:0] row_base;
  logic [CW-1:0]    h_fb;

  assign h_wrap = (h == H_MAX);
  assign v_next = (v == V_MAX) ? '0 : v + CW'(1);

  // Row base tracks (v >> SCALE_SHIFT) * row width incrementally, avoiding a multiplier.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h        <= H_MAX;
      v        <= V_MAX;
      row_base <= '0;
    end else if (en) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (h_wrap) begin
        h <= '0;
        v <= v_next;
        if (v_next == '0) begin
          row_base <= '0;
        end else if (v_next < V_ACT && (v_next & SUB_MASK) == '0) begin
          row_base <= row_base + ROW_W;
        end
      end else begin
        h <= h + CW'(1);
      end
    end
  end

  assign active      = (h < H_ACT) && (v < V_ACT);
  assign hsync       = (h >= HS_BEG && h < HS_END) ? H_POL : ~H_POL;
  assign vsync       = (v >= VS_BEG && v < VS_END) ? V_POL : ~V_POL;
  assign line_start  = (h == '0);
  assign frame_start = (h == '0) && (v == '0);

  assign h_fb    = h >> SCALE_SHIFT;
  assign fb_addr = active ? row_base + FB_AW'(h_fb) : '0;

  generate
    if (PIPE == 0) begin : g_nopipe
      assign hsync_d  = hsync;
      assign vsync_d  = vsync;
      assign active_d = active;
    end else begin : g_pipe
      localparam logic [2:0] IDLE = {~H_POL, ~V_POL, 1'b0};
      logic [2:0] dly [PIPE];

      // NOTE: the delay line is a handful of flops, not RAM, so it is reset to
      // keep the delayed syncs deasserted until real samples arrive.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < PIPE; i++) dly[i] <= IDLE;
        end else if (en) begin
          dly[0] <= {hsync, vsync, active};
          for (int i = 1; i < PIPE; i++) dly[i] <= dly[i-1];
        end
      end

      assign {hsync_d, vsync_d, active_d} = dly[PIPE-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a small mode with a scoreboarded model,
// a polarity/unscaled mode, and the default 1024x768 mode over its first lines.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic en_s = 1'b0, en_p = 1'b0, en_d = 1'b0;

  always #5 clk = ~clk;

  // Small mode: 16x8 active, H_TOTAL=24, V_TOTAL=12, scale 4, PIPE=2
  logic [7:0] s_h, s_v;
  logic       s_hsync, s_vsync, s_active, s_ls, s_fs, s_hsync_d, s_vsync_d, s_active_d;
  logic [5:0] s_fb;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FPORCH(2), .H_PULSE(3), .H_BPORCH(3),
    .V_ACTIVE(8),  .V_FPORCH(1), .V_PULSE(2), .V_BPORCH(1),
    .H_POL(1'b0), .V_POL(1'b0), .SCALE_SHIFT(2), .FB_AW(6), .PIPE(2), .CW(8)
  ) u_s (
    .clk(clk), .resetn(resetn), .en(en_s), .h(s_h), .v(s_v),
    .hsync(s_hsync), .vsync(s_vsync), .active(s_active),
    .line_start(s_ls), .frame_start(s_fs), .fb_addr(s_fb),
    .hsync_d(s_hsync_d), .vsync_d(s_vsync_d), .active_d(s_active_d)
  );

  // Positive polarity, unscaled 64x48, PIPE=0
  logic [7:0]  p_h, p_v;
  logic        p_hsync, p_vsync, p_active, p_ls, p_fs, p_hsync_d, p_vsync_d, p_active_d;
  logic [11:0] p_fb;

  vga_timing_gen #(
    .H_ACTIVE(64), .H_FPORCH(4), .H_PULSE(8), .H_BPORCH(4),
    .V_ACTIVE(48), .V_FPORCH(2), .V_PULSE(3), .V_BPORCH(3),
    .H_POL(1'b1), .V_POL(1'b1), .SCALE_SHIFT(0), .FB_AW(12), .PIPE(0), .CW(8)
  ) u_p (
    .clk(clk), .resetn(resetn), .en(en_p), .h(p_h), .v(p_v),
    .hsync(p_hsync), .vsync(p_vsync), .active(p_active),
    .line_start(p_ls), .frame_start(p_fs), .fb_addr(p_fb),
    .hsync_d(p_hsync_d), .vsync_d(p_vsync_d), .active_d(p_active_d)
  );

  // Default parameters
  logic [12:0] d_h, d_v;
  logic        d_hsync, d_vsync, d_active, d_ls, d_fs, d_hsync_d, d_vsync_d, d_active_d;
  logic [15:0] d_fb;

  vga_timing_gen u_d (
    .clk(clk), .resetn(resetn), .en(en_d), .h(d_h), .v(d_v),
    .hsync(d_hsync), .vsync(d_vsync), .active(d_active),
    .line_start(d_ls), .frame_start(d_fs), .fb_addr(d_fb),
    .hsync_d(d_hsync_d), .vsync_d(d_vsync_d), .active_d(d_active_d)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int   h, v, fb;
    logic hs, vs, act, ls, fs, hs_d, vs_d, act_d;
  } exp_t;

  typedef struct {
    logic en;
    int   h;
    logic act, act_d, hs, hs_d;
  } vec_t;

  exp_t       sb[$];
  int         mh, mv;
  logic [2:0] md1, md2;

  function automatic exp_t model_s(input int hh, input int vv, input logic [2:0] d2);
    exp_t e;
    e.h    = hh;
    e.v    = vv;
    e.act  = (hh < 16) && (vv < 8);
    e.hs   = !(hh >= 18 && hh < 21);
    e.vs   = !(vv >= 9 && vv < 11);
    e.ls   = (hh == 0);
    e.fs   = (hh == 0) && (vv == 0);
    e.fb   = e.act ? (vv / 4) * 4 + hh / 4 : 0;
    {e.hs_d, e.vs_d, e.act_d} = d2;
    return e;
  endfunction

  task automatic model_reset();
    mh  = 23;
    mv  = 11;
    md1 = 3'b110;
    md2 = 3'b110;
  endtask

  task automatic compare_s(input exp_t x);
    check("s.h",        32'(s_h),        32'(x.h));
    check("s.v",        32'(s_v),        32'(x.v));
    check("s.hsync",    32'(s_hsync),    32'(x.hs));
    check("s.vsync",    32'(s_vsync),    32'(x.vs));
    check("s.active",   32'(s_active),   32'(x.act));
    check("s.line",     32'(s_ls),       32'(x.ls));
    check("s.frame",    32'(s_fs),       32'(x.fs));
    check("s.fb_addr",  32'(s_fb),       32'(x.fb));
    check("s.hsync_d",  32'(s_hsync_d),  32'(x.hs_d));
    check("s.vsync_d",  32'(s_vsync_d),  32'(x.vs_d));
    check("s.active_d", 32'(s_active_d), 32'(x.act_d));
  endtask

  // Drive en on the falling edge, predict the post-edge state, compare #1 after the rising edge.
  task automatic step_s(input logic e);
    exp_t cur;
    @(negedge clk);
    en_s = e;
    if (e) begin
      cur = model_s(mh, mv, md2);
      md2 = md1;
      md1 = {cur.hs, cur.vs, cur.act};
      if (mh == 23) begin
        mh = 0;
        mv = (mv == 11) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    sb.push_back(model_s(mh, mv, md2));
    @(posedge clk);
    #1;
    compare_s(sb.pop_front());
  endtask

  vec_t tbl[7];

  initial begin
    int hs_cnt, hs_first, hsd_first, act_cnt, vs_lines, vs_first, pmis;

    // Active-to-blank edge at h=16 with en toggling; delayed outputs lag by two enabled edges.
    tbl[0] = '{1'b1, 16, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 16, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 17, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 18, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 18, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 19, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 20, 1'b0, 1'b0, 1'b0, 1'b0};

    model_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare_s(model_s(mh, mv, md2));
    check("p.rst_hsync",   32'(p_hsync),   32'd0);
    check("p.rst_vsync",   32'(p_vsync),   32'd0);
    check("p.rst_hsync_d", 32'(p_hsync_d), 32'd0);
    check("d.rst_h",       32'(d_h),       32'd1343);
    check("d.rst_v",       32'(d_v),       32'd805);
    check("d.rst_hsync_d", 32'(d_hsync_d), 32'd1);
    check("d.rst_active_d",32'(d_active_d),32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Small mode: walk to the last active pixel of line 0, then the en-toggle table.
    repeat (16) step_s(1'b1);
    for (int i = 0; i < 7; i++) begin
      step_s(tbl[i].en);
      check("tbl.h",        32'(s_h),        32'(tbl[i].h));
      check("tbl.v",        32'(s_v),        32'd0);
      check("tbl.active",   32'(s_active),   32'(tbl[i].act));
      check("tbl.active_d", 32'(s_active_d), 32'(tbl[i].act_d));
      check("tbl.hsync",    32'(s_hsync),    32'(tbl[i].hs));
      check("tbl.hsync_d",  32'(s_hsync_d),  32'(tbl[i].hs_d));
    end

    // Random enable over more than a full frame, scoreboarded against the model.
    for (int i = 0; i < 700; i++) step_s(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);

    // Asynchronous reset mid-frame, away from any clock edge.
    @(negedge clk);
    en_s = 1'b0;
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    compare_s(model_s(mh, mv, md2));
    @(negedge clk);
    resetn = 1'b1;
    step_s(1'b1);
    check("s.restart_frame", 32'(s_fs), 32'd1);
    check("s.restart_fb",    32'(s_fb), 32'd0);
    @(negedge clk);
    en_s = 1'b0;

    // Positive polarity, unscaled addressing, one full frame.
    hs_cnt = 0; hs_first = -1; vs_lines = 0; vs_first = -1; pmis = 0;
    @(negedge clk);
    en_p = 1'b1;
    for (int n = 1; n <= 80 * 56; n++) begin
      @(posedge clk);
      #1;
      if (n <= 80 && p_hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(p_h);
      end
      if (p_h == 8'd0 && p_vsync) begin
        vs_lines++;
        if (vs_first < 0) vs_first = int'(p_v);
      end
      if (p_hsync_d !== p_hsync || p_vsync_d !== p_vsync || p_active_d !== p_active) pmis++;
      if (n == 2 * 80 + 6) begin
        check("p.h_probe",  32'(p_h),  32'd5);
        check("p.v_probe",  32'(p_v),  32'd2);
        check("p.fb_probe", 32'(p_fb), 32'd133);
      end
    end
    @(negedge clk);
    en_p = 1'b0;
    check("p.hsync_width", 32'(hs_cnt),   32'd8);
    check("p.hsync_first", 32'(hs_first), 32'd68);
    check("p.vsync_lines", 32'(vs_lines), 32'd3);
    check("p.vsync_first", 32'(vs_first), 32'd50);
    check("p.pipe0_copy",  32'(pmis),     32'd0);

    // Default mode over the first five lines.
    hs_cnt = 0; hs_first = -1; hsd_first = -1; act_cnt = 0;
    @(negedge clk);
    en_d = 1'b1;
    for (int n = 1; n <= 4 * 1344 + 6; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        check("d.first_h",      32'(d_h),      32'd0);
        check("d.first_v",      32'(d_v),      32'd0);
        check("d.first_frame",  32'(d_fs),     32'd1);
        check("d.first_line",   32'(d_ls),     32'd1);
        check("d.first_active", 32'(d_active), 32'd1);
        check("d.first_fb",     32'(d_fb),     32'd0);
      end
      if (n <= 1344) begin
        if (!d_hsync) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(d_h);
        end
        if (!d_hsync_d && hsd_first < 0) hsd_first = int'(d_h);
        if (d_active) act_cnt++;
      end
      if (n == 1024) check("d.fb_last_active", 32'(d_fb), 32'd255);
      if (n == 1025) begin
        check("d.h_blank",      32'(d_h),      32'd1024);
        check("d.active_blank", 32'(d_active), 32'd0);
        check("d.fb_blank",     32'(d_fb),     32'd0);
      end
      if (n == 1344) check("d.line_end", 32'(d_ls), 32'd0);
      if (n == 1345) begin
        check("d.line2_start", 32'(d_ls), 32'd1);
        check("d.line2_frame", 32'(d_fs), 32'd0);
        check("d.line2_v",     32'(d_v),  32'd1);
      end
      if (n == 3 * 1344 + 4) begin
        check("d.h33", 32'(d_h),  32'd3);
        check("d.fb33", 32'(d_fb), 32'd0);
      end
      if (n == 4 * 1344 + 5) begin
        check("d.h44",  32'(d_h),  32'd4);
        check("d.v44",  32'(d_v),  32'd4);
        check("d.fb44", 32'(d_fb), 32'd257);
      end
    end
    @(negedge clk);
    en_d = 1'b0;
    check("d.hsync_width",   32'(hs_cnt),    32'd136);
    check("d.hsync_first",   32'(hs_first),  32'd1048);
    check("d.hsync_d_first", 32'(hsd_first), 32'd1049);
    check("d.active_width",  32'(act_cnt),   32'd1024);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
